// File: rtl/map_tile_renderer_pkg.sv
// ---------------------------------------------------------------------------
// map_defs: constants and helpers shared by the tile-map renderer.
//   - tile codes (sky, ground, brick, platform)
//   - RGB332 colour constants
//   - TILE_SHIFT (log2 of the tile edge in pixels)
//   - ctrl_state_e: control FSM states (map clear, then normal running)
//   - tile_colour(): colour of one pixel inside a tile, given its offsets
// ---------------------------------------------------------------------------
package map_defs;

    localparam int TILE_SHIFT = 4;

    typedef enum logic [1:0] {
        TILE_SKY      = 2'd0,
        TILE_GROUND   = 2'd1,
        TILE_BRICK    = 2'd2,
        TILE_PLATFORM = 2'd3
    } tile_code_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_e;

    localparam logic [7:0] COL_SKY    = 8'h57;
    localparam logic [7:0] COL_GROUND = 8'hA8;
    localparam logic [7:0] COL_BRICK  = 8'hC4;
    localparam logic [7:0] COL_MORTAR = 8'h92;
    localparam logic [7:0] COL_PLAT   = 8'h1C;
    localparam logic [7:0] COL_GRID   = 8'hFF;

    // Bricks are 8 pixels wide: mortar on the top row of the tile and on
    // every eighth column. Platforms are a 4-pixel slab over sky.
    function automatic logic [7:0] tile_colour(
        input tile_code_e            code,
        input logic [TILE_SHIFT-1:0] ox,
        input logic [TILE_SHIFT-1:0] oy
    );
        logic [7:0] colour;
        case (code)
            TILE_SKY:      colour = COL_SKY;
            TILE_GROUND:   colour = COL_GROUND;
            TILE_BRICK:    colour = (oy == '0 || (ox % TILE_SHIFT'(8)) == '0)
                                    ? COL_MORTAR : COL_BRICK;
            TILE_PLATFORM: colour = (oy < TILE_SHIFT'(4)) ? COL_PLAT : COL_SKY;
            default:       colour = COL_SKY;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/map_tile_ram.sv
// ---------------------------------------------------------------------------
// map_tile_ram: simple dual-port tile-map RAM, one write port and one
// synchronous read port. Read-first: a read and a write to the same address
// on the same edge return the old contents.
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  registered read data (one clock after i_raddr)
// ---------------------------------------------------------------------------
module map_tile_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // NOTE: the array has no reset so it maps onto block RAM; the owner
    // initialises it by writing every word. Non-blocking assignment makes the
    // read sample the pre-write contents, which is what gives read-first.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/map_tile_renderer.sv
// ---------------------------------------------------------------------------
// map_tile_renderer: pixel-colour stage behind the VGA timing generator.
// Looks up a horizontally scrolling tile map (tile edge 1<<TILE_SHIFT from
// map_defs) and emits RGB332 with syncs delayed to match, 3 clocks after
// pix_x/pix_y. After reset the map RAM is cleared (sky above GROUND_ROW,
// ground from it down) before init_done rises and tile writes are accepted.
//
// Ports:
//   clk, rst_n              pixel clock, async active-low reset
//   pix_x, pix_y            pixel coordinates from the timing generator
//   video_on                active-area flag
//   hsync_in, vsync_in      active-low syncs from the timing generator
//   frame_start             one-cycle pulse after the active area
//   scroll_req, scroll_dx   accumulate a signed pixel step (-8..+7)
//   wr_en, wr_addr, wr_data tile write {row, col} <= code
//   rgb                     RGB332 colour, 0 outside the active area
//   hsync_out, vsync_out    syncs delayed 3 clocks
//   init_done               map clear finished
//   scroll_x                scroll offset applied to the current frame
//
// Build option: define MAP_GRID_EN to draw 0xFF on the first row and column
// of every tile in the active area.
// ---------------------------------------------------------------------------
module map_tile_renderer
    import map_defs::*;
#(
    parameter int MAP_W_TILES = 64,
    parameter int MAP_H_TILES = 32,
    parameter int GROUND_ROW  = 28
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [9:0]                                          pix_x,
    input  logic [9:0]                                          pix_y,
    input  logic                                                video_on,
    input  logic                                                hsync_in,
    input  logic                                                vsync_in,
    input  logic                                                frame_start,
    input  logic                                                scroll_req,
    input  logic [3:0]                                          scroll_dx,
    input  logic                                                wr_en,
    input  logic [$clog2(MAP_H_TILES)+$clog2(MAP_W_TILES)-1:0] wr_addr,
    input  logic [1:0]                                          wr_data,
    output logic [7:0]                                          rgb,
    output logic                                                hsync_out,
    output logic                                                vsync_out,
    output logic                                                init_done,
    output logic [9:0]                                          scroll_x
);

    localparam int COL_W  = $clog2(MAP_W_TILES);
    localparam int ROW_W  = $clog2(MAP_H_TILES);
    localparam int ADDR_W = ROW_W + COL_W;

    // World width in pixels is a power of two, so the wrap is a mask.
    localparam logic [9:0]        WX_MASK        = 10'((MAP_W_TILES << TILE_SHIFT) - 1);
    localparam logic [ROW_W-1:0]  GROUND_ROW_IDX = ROW_W'(GROUND_ROW);
    localparam logic [ADDR_W-1:0] LAST_ADDR      = '1;

    // ---------------- control FSM and RAM write port ----------------
    ctrl_state_e       r_state;
    ctrl_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [1:0]        w_ram_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_waddr = wr_addr;
        w_ram_wdata = wr_data;
        case (r_state)
            ST_CLEAR: begin
                // The clear owns the write port; game-logic writes are dropped.
                w_ram_we    = 1'b1;
                w_ram_waddr = r_clr_cnt;
                w_ram_wdata = (r_clr_cnt[ADDR_W-1 -: ROW_W] >= GROUND_ROW_IDX)
                              ? TILE_GROUND : TILE_SKY;
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ram_we = wr_en;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    assign init_done = (r_state == ST_RUN);

    // ---------------- scroll accumulation ----------------
    // Requests collect in r_pending and are applied only at frame_start, so
    // the offset is constant for every pixel of a frame.
    logic [9:0] r_scroll_x;
    logic [9:0] r_pending;
    logic [9:0] w_dx_ext;
    logic [9:0] w_req_dx;

    assign w_dx_ext = {{6{scroll_dx[3]}}, scroll_dx};
    assign w_req_dx = scroll_req ? w_dx_ext : 10'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scroll_x <= '0;
            r_pending  <= '0;
        end else if (frame_start) begin
            r_scroll_x <= r_scroll_x + r_pending + w_req_dx;
            r_pending  <= '0;
        end else begin
            r_pending <= r_pending + w_req_dx;
        end
    end

    assign scroll_x = r_scroll_x;

    // ---------------- stage 1: address and offsets ----------------
    logic [9:0]            w_wx;
    logic [ADDR_W-1:0]     w_rd_addr;
    logic                  w_unused;

    assign w_wx      = (pix_x + r_scroll_x) & WX_MASK;
    assign w_rd_addr = {pix_y[TILE_SHIFT +: ROW_W], w_wx[TILE_SHIFT +: COL_W]};
    // Rows past the map height only occur in vertical blanking.
    assign w_unused  = ^{pix_y, w_wx};

    logic [ADDR_W-1:0]     r_s1_addr;
    logic [TILE_SHIFT-1:0] r_s1_ox, r_s1_oy, r_s2_ox, r_s2_oy;
    logic                  r_s1_vid, r_s1_hs, r_s1_vs, r_s1_vld;
    logic                  r_s2_vid, r_s2_hs, r_s2_vs, r_s2_vld;
    logic [7:0]            r_rgb;
    logic                  r_s3_hs, r_s3_vs;
    logic [1:0]            w_ram_q;
    logic [7:0]            w_colour;

    map_tile_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (r_s1_addr),
        .o_rdata (w_ram_q)
    );

    // Stage 3 colour; the valid bit keeps rgb dark while the map is being
    // cleared and until the first pixel sampled in RUN has drained through.
    always_comb begin
        w_colour = tile_colour(tile_code_e'(w_ram_q), r_s2_ox, r_s2_oy);
`ifdef MAP_GRID_EN
        if (r_s2_ox == '0 || r_s2_oy == '0) begin
            w_colour = COL_GRID;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_addr <= '0;
            r_s1_ox   <= '0;
            r_s1_oy   <= '0;
            r_s1_vid  <= 1'b0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
            r_s1_vld  <= 1'b0;
            r_s2_ox   <= '0;
            r_s2_oy   <= '0;
            r_s2_vid  <= 1'b0;
            r_s2_hs   <= 1'b1;
            r_s2_vs   <= 1'b1;
            r_s2_vld  <= 1'b0;
            r_rgb     <= 8'h00;
            r_s3_hs   <= 1'b1;
            r_s3_vs   <= 1'b1;
        end else begin
            r_s1_addr <= w_rd_addr;
            r_s1_ox   <= w_wx[TILE_SHIFT-1:0];
            r_s1_oy   <= pix_y[TILE_SHIFT-1:0];
            r_s1_vid  <= video_on;
            r_s1_hs   <= hsync_in;
            r_s1_vs   <= vsync_in;
            r_s1_vld  <= (r_state == ST_RUN);
            // Stage 2: RAM output lands this edge; side-band follows it.
            r_s2_ox   <= r_s1_ox;
            r_s2_oy   <= r_s1_oy;
            r_s2_vid  <= r_s1_vid;
            r_s2_hs   <= r_s1_hs;
            r_s2_vs   <= r_s1_vs;
            r_s2_vld  <= r_s1_vld;
            r_rgb     <= (r_s2_vld && r_s2_vid) ? w_colour : 8'h00;
            r_s3_hs   <= r_s2_hs;
            r_s3_vs   <= r_s2_vs;
        end
    end

    assign rgb       = r_rgb;
    assign hsync_out = r_s3_hs;
    assign vsync_out = r_s3_vs;

endmodule

// File: tb/tb_map_tile_renderer.sv
// ---------------------------------------------------------------------------
// Testbench for map_tile_renderer. Pixels are streamed one per clock; a
// reference model (tile map array plus integer scroll arithmetic) predicts
// rgb, and the expected values travel through a 3-deep queue to line up with
// the 3-clock latency. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_map_tile_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = '0, pix_y = '0;
    logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic        frame_start = 1'b0, scroll_req = 1'b0;
    logic [3:0]  scroll_dx = '0;
    logic        wr_en = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [1:0]  wr_data = '0;
    logic [7:0]  rgb;
    logic        hsync_out, vsync_out, init_done;
    logic [9:0]  scroll_x;

    always #5 clk = ~clk;

    map_tile_renderer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .video_on    (video_on),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .frame_start (frame_start),
        .scroll_req  (scroll_req),
        .scroll_dx   (scroll_dx),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rgb         (rgb),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .init_done   (init_done),
        .scroll_x    (scroll_x)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    logic [1:0] model_ram [0:2047];
    int         model_sx = 0;
    int         model_pend = 0;
    bit         model_run = 0;
    logic [7:0] q_rgb [$];
    logic       q_hs [$];
    logic       q_vs [$];

    function automatic int wrap10(input int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    function automatic void model_clear();
        for (int a = 0; a < 2048; a++) begin
            model_ram[a] = ((a / 64) >= 28) ? 2'd1 : 2'd0;
        end
    endfunction

    function automatic logic [7:0] ref_colour(input int px, input int py, input int sx);
        int wx, col, row, ox, oy;
        logic [1:0] code;
        wx   = (px + sx) % 1024;
        col  = wx / 16;
        ox   = wx % 16;
        row  = (py / 16) % 32;
        oy   = py % 16;
        code = model_ram[row * 64 + col];
`ifdef MAP_GRID_EN
        if (ox == 0 || oy == 0) return 8'hFF;
`endif
        case (code)
            2'd0:    return 8'h57;
            2'd1:    return 8'hA8;
            2'd2:    return (oy == 0 || ox % 8 == 0) ? 8'h92 : 8'hC4;
            default: return (oy < 4) ? 8'h1C : 8'h57;
        endcase
    endfunction

    // One clock of streaming: predict, advance the model, wait, compare.
    task automatic tick();
        logic [7:0] e_rgb;
        logic       e_hs, e_vs;
        int         dx;
        dx = int'($signed(scroll_dx));
        if (wr_en && model_run) model_ram[wr_addr] = wr_data;
        q_rgb.push_back((video_on && model_run) ? ref_colour(pix_x, pix_y, model_sx) : 8'h00);
        q_hs.push_back(hsync_in);
        q_vs.push_back(vsync_in);
        if (frame_start) begin
            model_sx   = wrap10(model_sx + model_pend + (scroll_req ? dx : 0));
            model_pend = 0;
        end else if (scroll_req) begin
            model_pend = wrap10(model_pend + dx);
        end
        @(negedge clk);
        wr_en = 1'b0; scroll_req = 1'b0; frame_start = 1'b0;
        n_cmp++;
        if (scroll_x !== 10'(model_sx)) begin
            n_bad++;
            $display("FAIL scroll_x: got %0d expected %0d", scroll_x, model_sx);
        end
        if (q_rgb.size() == 3) begin
            e_rgb = q_rgb.pop_front();
            e_hs  = q_hs.pop_front();
            e_vs  = q_vs.pop_front();
            n_cmp += 3;
            if (rgb !== e_rgb) begin
                n_bad++;
                $display("FAIL rgb @%0t: got %02h expected %02h", $time, rgb, e_rgb);
            end
            if (hsync_out !== e_hs) begin
                n_bad++;
                $display("FAIL hsync_out @%0t: got %b expected %b", $time, hsync_out, e_hs);
            end
            if (vsync_out !== e_vs) begin
                n_bad++;
                $display("FAIL vsync_out @%0t: got %b expected %b", $time, vsync_out, e_vs);
            end
        end
    endtask

    task automatic set_pix(input int x, input int y);
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        video_on = 1'b1;
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
    endtask

    task automatic rand_pix(input int xmax, input int ymax);
        set_pix($urandom_range(0, xmax), $urandom_range(0, ymax));
    endtask

    task automatic flush();
        repeat (3) begin
            video_on = 1'b0;
            tick();
        end
    endtask

    // Called with rst_n low: releases reset and follows the 2048-cycle clear.
    task automatic do_clear();
        q_rgb.delete(); q_hs.delete(); q_vs.delete();
        model_run = 0;
        set_pix(5, 5);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 2048; i++) begin
            @(posedge clk);
            #1;
            // A write landing mid-clear must be dropped (address 0 is already done).
            if (i == 1000) begin wr_en = 1'b1; wr_addr = 11'd0; wr_data = 2'd3; end
            if (i == 1001) wr_en = 1'b0;
            if (i == 2047 || i == 2048) begin
                n_cmp += 2;
                if (init_done !== (i == 2048)) begin
                    n_bad++;
                    $display("FAIL init_done cycle %0d: got %b expected %b", i, init_done, (i == 2048));
                end
                if (rgb !== 8'h00) begin
                    n_bad++;
                    $display("FAIL rgb during clear cycle %0d: got %02h expected 00", i, rgb);
                end
            end
        end
        wr_en = 1'b0;
        @(negedge clk);
        model_clear();
        model_sx   = 0;
        model_pend = 0;
        model_run  = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp += 5;
        if (rgb !== 8'h00)     begin n_bad++; $display("FAIL reset rgb: got %02h expected 00", rgb); end
        if (hsync_out !== 1'b1) begin n_bad++; $display("FAIL reset hsync_out: got %b expected 1", hsync_out); end
        if (vsync_out !== 1'b1) begin n_bad++; $display("FAIL reset vsync_out: got %b expected 1", vsync_out); end
        if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset init_done: got %b expected 0", init_done); end
        if (scroll_x !== 10'd0) begin n_bad++; $display("FAIL reset scroll_x: got %0d expected 0", scroll_x); end
        do_clear();
    endtask

    task automatic test_clear_content();
        set_pix(0, 448);  tick();
        set_pix(0, 0);    tick();
        set_pix(16, 5);   tick();
        repeat (150) begin rand_pix(639, 479); tick(); end
        flush();
    endtask

    task automatic test_tile_write();
        video_on = 1'b0;
        wr_en = 1'b1; wr_addr = {5'd1, 6'd2}; wr_data = 2'd2;
        tick();
        set_pix(32, 16); tick();
        set_pix(33, 17); tick();
        // Writes and reads confined to a small window so they collide often.
        repeat (300) begin
            rand_pix(127, 63);
            if ($urandom_range(0, 9) < 3) begin
                wr_en   = 1'b1;
                wr_addr = {5'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
                wr_data = 2'($urandom);
            end
            tick();
        end
        flush();
    endtask

    task automatic test_scroll();
        int delta;
        repeat (3) begin
            rand_pix(639, 479);
            scroll_req = 1'b1; scroll_dx = 4'd7;
            tick();
        end
        rand_pix(639, 479); frame_start = 1'b1; tick();
        n_cmp++;
        if (scroll_x !== 10'd21) begin n_bad++; $display("FAIL scroll_x after 3x+7: got %0d expected 21", scroll_x); end
        repeat (2) begin
            rand_pix(639, 479); scroll_req = 1'b1; scroll_dx = 4'hD; tick();
        end
        rand_pix(639, 479); frame_start = 1'b1; scroll_req = 1'b1; scroll_dx = 4'd5; tick();
        n_cmp++;
        if (scroll_x !== 10'd20) begin n_bad++; $display("FAIL scroll_x with req on frame_start: got %0d expected 20", scroll_x); end
        // Walk the offset to 1020 with +7 steps.
        delta = wrap10(1020 - model_sx);
        while (delta > 0) begin
            rand_pix(639, 479);
            scroll_req = 1'b1;
            scroll_dx  = 4'((delta > 7) ? 7 : delta);
            delta      = delta - ((delta > 7) ? 7 : delta);
            tick();
        end
        frame_start = 1'b1; tick();
        n_cmp++;
        if (scroll_x !== 10'd1020) begin n_bad++; $display("FAIL scroll_x setup: got %0d expected 1020", scroll_x); end
        frame_start = 1'b1; scroll_req = 1'b1; scroll_dx = 4'd7; tick();
        n_cmp++;
        if (scroll_x !== 10'd3) begin n_bad++; $display("FAIL scroll_x wrap up: got %0d expected 3", scroll_x); end
        frame_start = 1'b1; scroll_req = 1'b1; scroll_dx = 4'h8; tick();
        n_cmp++;
        if (scroll_x !== 10'd1019) begin n_bad++; $display("FAIL scroll_x wrap down: got %0d expected 1019", scroll_x); end
        // With offset 1019, screen column 0 falls in map column 63.
        video_on = 1'b0;
        wr_en = 1'b1; wr_addr = {5'd5, 6'd63}; wr_data = 2'd2; tick();
        wr_en = 1'b1; wr_addr = {5'd5, 6'd0};  wr_data = 2'd3; tick();
        for (int x = 0; x < 24; x++) begin set_pix(x, 81); tick(); end
        repeat (200) begin
            rand_pix(639, 479);
            if ($urandom_range(0, 9) < 3) begin scroll_req = 1'b1; scroll_dx = 4'($urandom); end
            if ($urandom_range(0, 19) == 0) frame_start = 1'b1;
            tick();
        end
        flush();
    endtask

    task automatic test_video_off();
        repeat (100) begin
            rand_pix(639, 479);
            video_on = 1'($urandom);
            tick();
        end
        flush();
    endtask

    task automatic test_reset_midframe();
        repeat (2) begin rand_pix(639, 479); scroll_req = 1'b1; scroll_dx = 4'd5; tick(); end
        rand_pix(639, 479); tick();
        rand_pix(639, 479);
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (rgb !== 8'h00)      begin n_bad++; $display("FAIL midframe reset rgb: got %02h expected 00", rgb); end
        if (hsync_out !== 1'b1) begin n_bad++; $display("FAIL midframe reset hsync_out: got %b expected 1", hsync_out); end
        if (vsync_out !== 1'b1) begin n_bad++; $display("FAIL midframe reset vsync_out: got %b expected 1", vsync_out); end
        if (scroll_x !== 10'd0) begin n_bad++; $display("FAIL midframe reset scroll_x: got %0d expected 0", scroll_x); end
        if (init_done !== 1'b0) begin n_bad++; $display("FAIL midframe reset init_done: got %b expected 0", init_done); end
        do_clear();
        rand_pix(639, 479); frame_start = 1'b1; tick();
        n_cmp++;
        if (scroll_x !== 10'd0) begin n_bad++; $display("FAIL pending after reset: got %0d expected 0", scroll_x); end
        repeat (100) begin rand_pix(639, 479); tick(); end
        flush();
    endtask

    initial begin
        test_reset();
        test_clear_content();
        test_tile_write();
        test_scroll();
        test_video_off();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/map_tile_renderer.md
# map_tile_renderer

Pixel-colour stage that sits directly downstream of the VGA timing generator. It consumes the generator's pixel coordinates, video_on and syncs, and looks up a horizontally scrolling 16x16-pixel tile map. It emits an RGB332 colour with delayed syncs toward the DAC pins. It owns the tile-map RAM: it clears it to a default level after reset and accepts tile writes from game logic.

## Interface
- MAP_W_TILES, 64: map width in tiles; power of 2.
- MAP_H_TILES, 32: map height in tiles; power of 2; rows 0..29 visible.
- TILE_SHIFT, 4: log2 tile edge in pixels.
- GROUND_ROW, 28: first row filled with ground tiles on clear.
- clk  in  1  pixel clock (25 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- pix_x  in  10  current pixel column from timing generator.
- pix_y  in  10  current pixel row.
- video_on  in  1  high in active area.
- hsync_in, vsync_in  in  1 each  syncs from timing generator (active-low).
- frame_start  in  1  one-cycle pulse at first blanking line after the active area.
- scroll_req  in  1  accumulate scroll_dx this cycle.
- scroll_dx  in  4  signed pixel step, -8..+7.
- wr_en  in  1  tile write strobe.
- wr_addr  in  11  {row[4:0], col[5:0]}.
- wr_data  in  2  tile code.
- rgb  out  8  RGB332 colour {R[2:0],G[2:0],B[1:0]}.
- hsync_out, vsync_out  out  1 each  syncs delayed to match rgb.
- init_done  out  1  high once map clear completes.
- scroll_x  out  10  current applied scroll offset in pixels.

## Operation
- Control FSM: CLEAR -> RUN. Reset enters CLEAR with an 11-bit counter at 0.
- CLEAR writes one tile per cycle: code 1 (ground) when row >= GROUND_ROW, else 0 (sky). After address 2047 it goes to RUN and asserts init_done. External writes are ignored in CLEAR.
- RUN: wr_en writes wr_data at wr_addr. RAM is read-first, so a same-address read in the same cycle returns old data.
- Scroll: each scroll_req adds sign-extended scroll_dx into a 10-bit pending register, modulo 1024. On frame_start, scroll_x <= scroll_x + pending (+ scroll_dx if scroll_req is also high), and pending clears. scroll_x therefore never changes mid-frame.
- World column: wx = (pix_x + scroll_x) mod (MAP_W_TILES<<TILE_SHIFT). Tile col = wx>>4. Tile row = pix_y>>4. Offsets ox = wx[3:0], oy = pix_y[3:0].
- Tile codes and colours:
  - 0 sky: 0x57.
  - 1 ground: 0xA8.
  - 2 brick: 0x92 mortar when oy==0 or ox[2:0]==0, else 0xC4.
  - 3 platform: 0x1C when oy<4, else 0x57.
- rgb = 0x00 whenever the delayed video_on is low, or while in CLEAR.

## Timing
- Stage 1 registers the RAM address, ox, oy, video_on and syncs. Stage 2 is the RAM output plus delayed side-band. Stage 3 registers rgb and syncs.
- Latency is 3 clocks from pix_x/pix_y to rgb. hsync_out and vsync_out are the inputs delayed exactly 3 clocks.
- Reset values: rgb 0x00, hsync_out 1, vsync_out 1, init_done 0, scroll_x 0, pending 0, pipeline valid bits 0.
- CLEAR lasts 2048 cycles; init_done rises on cycle 2048 after reset release.
- Reset mid-frame or mid-clear restarts CLEAR and discards pending scroll.
- scroll_x wraps: 1020 + 7 becomes 3; 2 - 8 becomes 1018.

## Configuration
- MAP_GRID_EN defined: in the active area, pixels with ox==0 or oy==0 output 0xFF, overriding the tile colour. Latency is unchanged.
- MAP_GRID_EN undefined: no overlay and no grid logic is present.

## Structure
- Shared package map_defs holds:
  - tile codes TILE_SKY/GROUND/BRICK/PLATFORM;
  - colour constants COL_SKY=0x57, COL_GROUND=0xA8, COL_BRICK=0xC4, COL_MORTAR=0x92, COL_PLAT=0x1C, COL_GRID=0xFF;
  - TILE_SHIFT.
- One sub-module, map_tile_ram: 2048x2 simple dual-port RAM, synchronous read-first, one write port and one read port.

## Test plan
- Reset, run 2048 cycles -> init_done rises on cycle 2048; pix (0,448) returns 0xA8 and pix (0,0) returns 0x57, both after 3 cycles.
- Write code 2 at {row 1, col 2}; pix (32,16) -> 0x92; pix (33,17) -> 0xC4; syncs delayed 3 cycles.
- scroll_req dx=+7 three times mid-frame -> scroll_x stays 0 until frame_start, then becomes 21; scroll_req on the frame_start cycle is also included.
- scroll_x=1020, dx=+7 applied -> 3; then dx=-8 -> 1019; pix_x=0 maps to tile col 63.
- Drive video_on=0 -> rgb 0x00. Assert rst_n low mid-frame -> rgb 0, syncs 1, scroll_x 0, CLEAR restarts.
- With MAP_GRID_EN, pix (16,5) -> 0xFF. Without it -> the tile colour.
